// File: rtl/c4_pkg.sv
// Shared constants and hold-state encoding for the button front end.
package c4_pkg;

    localparam int DEFAULT_DEBOUNCE_CLKS = 2500000;
    localparam int DEFAULT_REPEAT_DELAY  = 12500000;
    localparam int DEFAULT_REPEAT_RATE   = 5000000;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_t;

endpackage

// File: rtl/btn_input_conditioner_if.sv
// Control inputs and conditioned button outputs of the front end.
interface btn_input_conditioner_if #(
    parameter int N_BUTTONS = 3
);
    logic                 e_debug;
    logic [N_BUTTONS-1:0] repeat_en;
    logic [N_BUTTONS-1:0] btns_in;
    logic [N_BUTTONS-1:0] btns_level;
    logic [N_BUTTONS-1:0] btns_press;
    logic [N_BUTTONS-1:0] btns_release;
    logic                 any_active;

    modport master (
        output e_debug, repeat_en, btns_in,
        input  btns_level, btns_press, btns_release, any_active
    );

    modport slave (
        input  e_debug, repeat_en, btns_in,
        output btns_level, btns_press, btns_release, any_active
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// One button: synchroniser, debounce, edge pulses and auto-repeat FSM.
module btn_conditioner_channel
    import c4_pkg::*;
#(
    parameter int CLKS_TO_WAIT = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic e_debug_i,
    input  logic repeat_en_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW   = (CLKS_TO_WAIT > 2) ? $clog2(CLKS_TO_WAIT) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q;
    logic [HW-1:0]          hcnt_q, hlim;
    hold_state_t            state_q;
    logic                   sync, rise, fall, hold_abort;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (e_debug_i) begin
            level_d = sync;
            cnt_d   = '0;
        end else if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CLKS_TO_WAIT - 1)) begin
            level_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise       = level_d & ~level_q;
    assign fall       = ~level_d & level_q;
    // Judged on next level so a repeat can never coincide with release.
    assign hold_abort = ~level_d | ~repeat_en_i | e_debug_i;
    assign hlim       = (state_q == HOLD_REPEAT) ? HW'(REPEAT_RATE - 1)
                                                 : HW'(REPEAT_DELAY - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hcnt_q    <= '0;
            state_q   <= HOLD_IDLE;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            unique case (state_q)
                HOLD_IDLE: begin
                    hcnt_q <= '0;
                    if (rise && repeat_en_i && !e_debug_i)
                        state_q <= HOLD_DELAY;
                end
                HOLD_DELAY, HOLD_REPEAT: begin
                    if (hold_abort) begin
                        state_q <= HOLD_IDLE;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == hlim) begin
                        press_q <= 1'b1;
                        state_q <= HOLD_REPEAT;
                        hcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= HOLD_IDLE;
                    hcnt_q  <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_input_conditioner.sv
// N-channel push-button front end: one conditioner per button plus any_active.
module btn_input_conditioner
    import c4_pkg::*;
#(
    parameter int N_BUTTONS    = 3,
    parameter int CLKS_TO_WAIT = DEFAULT_DEBOUNCE_CLKS,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input logic              clk,
    input logic              rst,
    btn_input_conditioner_if.slave bus
);
    logic [N_BUTTONS-1:0] level_w;
    logic [N_BUTTONS-1:0] press_w;
    logic [N_BUTTONS-1:0] release_w;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        btn_conditioner_channel #(
            .CLKS_TO_WAIT(CLKS_TO_WAIT),
            .SYNC_STAGES (SYNC_STAGES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .e_debug_i  (bus.e_debug),
            .repeat_en_i(bus.repeat_en[i]),
            .btn_i      (bus.btns_in[i]),
            .level_o    (level_w[i]),
            .press_o    (press_w[i]),
            .release_o  (release_w[i])
        );
    end

    assign bus.btns_level   = level_w;
    assign bus.btns_press   = press_w;
    assign bus.btns_release = release_w;
    assign bus.any_active   = |level_w;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Directed bench for btn_input_conditioner with short debounce/repeat timing.
module tb_btn_input_conditioner;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    btn_input_conditioner_if #(.N_BUTTONS(3)) bif ();

    btn_input_conditioner #(
        .N_BUTTONS   (3),
        .CLKS_TO_WAIT(4),
        .SYNC_STAGES (2),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.e_debug = 1'b0;
        bif.repeat_en = 3'b000;
        bif.btns_in = 3'b000;
        step(2);
        total++;
        if (bif.btns_level !== 3'b000) begin
            bad++;
            $display("FAIL reset_level got=%b exp=000", bif.btns_level);
        end
        total++;
        if (bif.btns_press !== 3'b000) begin
            bad++;
            $display("FAIL reset_press got=%b exp=000", bif.btns_press);
        end
        total++;
        if (bif.btns_release !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got=%b exp=000", bif.btns_release);
        end
        total++;
        if (bif.any_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_any got=%b exp=0", bif.any_active);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_clean_press();
        bif.btns_in = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            total++;
            if (bif.btns_level !== ((k >= 6) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL clean_level k=%0d got=%b", k, bif.btns_level);
            end
            total++;
            if (bif.btns_press !== ((k == 6) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL clean_press k=%0d got=%b", k, bif.btns_press);
            end
        end
        bif.btns_in = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            total++;
            if (bif.btns_release !== ((k == 6) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL clean_release k=%0d got=%b", k, bif.btns_release);
            end
            total++;
            if (bif.btns_level !== ((k < 6) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL clean_fall k=%0d got=%b", k, bif.btns_level);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            bif.btns_in = {1'b0, pat[k], 1'b0};
            step(1);
            total++;
            if (bif.btns_press !== 3'b000) begin
                bad++;
                $display("FAIL bounce_quiet k=%0d got=%b", k, bif.btns_press);
            end
        end
        bif.btns_in = 3'b010;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            total++;
            if (bif.btns_press !== ((k == 6) ? 3'b010 : 3'b000)) begin
                bad++;
                $display("FAIL bounce_press k=%0d got=%b", k, bif.btns_press);
            end
        end
        bif.btns_in = 3'b000;
        step(8);
        total++;
        if (bif.btns_level !== 3'b000) begin
            bad++;
            $display("FAIL bounce_settle got=%b exp=000", bif.btns_level);
        end
    endtask

    task automatic test_repeat();
        logic pexp;
        bif.repeat_en = 3'b100;
        bif.btns_in = 3'b100;
        for (int k = 1; k <= 45; k++) begin
            step(1);
            pexp = (k == 6) || (k >= 16 && k <= 34 && ((k - 16) % 3) == 0);
            total++;
            if (bif.btns_press !== {pexp, 2'b00}) begin
                bad++;
                $display("FAIL repeat_press k=%0d got=%b exp=%b", k, bif.btns_press, {pexp, 2'b00});
            end
            total++;
            if (bif.btns_release !== ((k == 36) ? 3'b100 : 3'b000)) begin
                bad++;
                $display("FAIL repeat_release k=%0d got=%b", k, bif.btns_release);
            end
            if (k == 30)
                bif.btns_in = 3'b000;
        end
        bif.repeat_en = 3'b000;
    endtask

    task automatic test_debug();
        bif.e_debug = 1'b1;
        bif.btns_in = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 1)
                bif.btns_in = 3'b000;
            total++;
            if (bif.btns_level !== ((k == 3) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL debug_level k=%0d got=%b", k, bif.btns_level);
            end
            total++;
            if (bif.btns_press !== ((k == 3) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL debug_press k=%0d got=%b", k, bif.btns_press);
            end
            total++;
            if (bif.btns_release !== ((k == 4) ? 3'b001 : 3'b000)) begin
                bad++;
                $display("FAIL debug_release k=%0d got=%b", k, bif.btns_release);
            end
        end
        bif.e_debug = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid();
        bif.repeat_en = 3'b100;
        bif.btns_in = 3'b100;
        step(14);
        bif.btns_in = 3'b101;
        step(3);
        rst = 1'b1;
        step(1);
        total++;
        if (bif.btns_level !== 3'b000 || bif.any_active !== 1'b0) begin
            bad++;
            $display("FAIL midrst_level got=%b any=%b exp=000/0", bif.btns_level, bif.any_active);
        end
        total++;
        if (bif.btns_press !== 3'b000 || bif.btns_release !== 3'b000) begin
            bad++;
            $display("FAIL midrst_pulse press=%b rel=%b exp=000", bif.btns_press, bif.btns_release);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            total++;
            if (bif.btns_level !== ((k >= 6) ? 3'b101 : 3'b000)) begin
                bad++;
                $display("FAIL midrst_relevel k=%0d got=%b", k, bif.btns_level);
            end
            total++;
            if (bif.btns_press !== ((k == 6) ? 3'b101 : 3'b000)) begin
                bad++;
                $display("FAIL midrst_press k=%0d got=%b", k, bif.btns_press);
            end
        end
        bif.repeat_en = 3'b000;
        bif.btns_in = 3'b000;
        step(10);
    endtask

    task automatic test_simultaneous();
        bif.btns_in = 3'b111;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            total++;
            if (bif.btns_press !== ((k == 6) ? 3'b111 : 3'b000)) begin
                bad++;
                $display("FAIL simul_press k=%0d got=%b", k, bif.btns_press);
            end
            total++;
            if (bif.any_active !== (k >= 6)) begin
                bad++;
                $display("FAIL simul_any k=%0d got=%b", k, bif.any_active);
            end
        end
        bif.btns_in = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            total++;
            if (bif.btns_release !== ((k == 6) ? 3'b111 : 3'b000)) begin
                bad++;
                $display("FAIL simul_release k=%0d got=%b", k, bif.btns_release);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bif.e_debug = 1'b0;
        bif.repeat_en = 3'b000;
        bif.btns_in = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_debug();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
